conv_inst_sequencer: RTL and testbench

- Hardware instruction sequencer that drives the 50-bit inst bus of core. It replaces bench-driven stimulus for one full convolution pass.
- For each kernel position (kij) it runs three phases in order:
  - stream col weight rows from xmem into L0 and load them into the array;
  - stream len_nij activation rows from xmem and execute;
  - issue a one-cycle flush.
- In parallel it drains OFIFO into pmem at sequential addresses.
- Sits directly upstream of core; the only feedback it uses is l0_ready and ofifo_valid.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/psum_drain_ctrl.sv | 71 +++++++
 rtl/conv_inst_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_conv_inst_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction bus and the convolution
// instruction sequencer: field positions, address types and FSM states.
package core_pkg;

    localparam int INST_W = 50;
    localparam int XA_W   = 11;
    localparam int PA_W   = 14;

    // Bit positions of the 50-bit core instruction word.
    localparam int B_ACC        = 49;
    localparam int B_CEN_PMEM   = 48;
    localparam int B_WEN_PMEM   = 47;
    localparam int B_A_PMEM_MSB = 46;
    localparam int B_A_PMEM_LSB = 33;
    localparam int B_CEN1       = 32;
    localparam int B_A1_MSB     = 31;
    localparam int B_A1_LSB     = 21;
    localparam int B_CEN0       = 20;
    localparam int B_WEN0       = 19;
    localparam int B_A0_MSB     = 18;
    localparam int B_A0_LSB     = 8;
    localparam int B_OFIFO_RD   = 7;
    localparam int B_IFIFO_WR   = 6;
    localparam int B_IFIFO_RD   = 5;
    localparam int B_L0_RD      = 4;
    localparam int B_L0_WR      = 3;
    localparam int B_MODE       = 2;
    localparam int B_EXECUTE    = 1;
    localparam int B_LOAD       = 0;

    typedef logic [XA_W-1:0] xaddr_t;
    typedef logic [PA_W-1:0] paddr_t;
    // One extra bit so a full 2^PA_W-row drain count is representable.
    typedef logic [PA_W:0]   dcnt_t;

    // xmem address of kernel position 0, weight row 0.
    localparam xaddr_t W_BASE = 11'h400;

    // Control triple carried through the delay line: {mode, execute, load}.
    localparam logic [2:0] CTL_NONE  = 3'b000;
    localparam logic [2:0] CTL_LOAD  = 3'b001;
    localparam logic [2:0] CTL_EXEC  = 3'b010;
    localparam logic [2:0] CTL_FLUSH = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_EXEC       = 3'd2,
        S_FLUSH      = 3'd3,
        S_NEXT       = 3'd4,
        S_WAIT_DRAIN = 3'd5,
        S_DONE       = 3'd6
    } seq_state_t;

endpackage

// File: rtl/psum_drain_ctrl.sv
// Drains complete psum rows from OFIFO into pmem at sequential addresses.
// The read strobe is combinational so no row beyond the expected count is
// ever popped.
module psum_drain_ctrl
    import core_pkg::*;
#(
    parameter int TOTAL = 9216
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   en,
    input  logic   ofifo_valid,
    output logic   ofifo_rd,
    output logic   cen_pmem,
    output logic   wen_pmem,
    output paddr_t a_pmem,
    output dcnt_t  drain_cnt
);

    localparam dcnt_t TOTAL_C = dcnt_t'(TOTAL);

    dcnt_t  cnt_q, cnt_d;
    paddr_t wr_ptr_q, wr_ptr_d;
    logic   rd_s;

    // Decide whether a row moves this cycle and advance the counters.
    always_comb begin
        rd_s     = en && ofifo_valid && (cnt_q < TOTAL_C);
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (clr) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
        end else if (rd_s) begin
            cnt_d    = cnt_q + dcnt_t'(1'b1);
            wr_ptr_d = wr_ptr_q + paddr_t'(1'b1);
        end else begin
            cnt_d    = cnt_q;
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Drive the pmem write fields in the same cycle as the OFIFO pop.
    always_comb begin
        ofifo_rd = rd_s;
        if (rd_s) begin
            cen_pmem = 1'b0;
            wen_pmem = 1'b0;
            a_pmem   = wr_ptr_q;
        end else begin
            cen_pmem = 1'b1;
            wen_pmem = 1'b1;
            a_pmem   = '0;
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign drain_cnt = cnt_q;

endmodule

// File: rtl/conv_inst_sequencer.sv
// Instruction sequencer for one full convolution pass: per kernel position
// it loads col weight rows, executes len_nij activation rows and flushes,
// while psum rows are drained to pmem in parallel.
module conv_inst_sequencer
    import core_pkg::*;
#(
    parameter int COL     = 8,
    parameter int LEN_NIJ = 1024,
    parameter int LEN_KIJ = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              l0_ready,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int T_W = (LEN_NIJ > COL) ? $clog2(LEN_NIJ) : $clog2(COL);
    localparam int K_W = $clog2(LEN_KIJ + 1);

    typedef logic [T_W-1:0] t_cnt_t;
    typedef logic [K_W-1:0] kij_t;

    localparam t_cnt_t COL_LAST = t_cnt_t'(COL - 1);
    localparam t_cnt_t NIJ_LAST = t_cnt_t'(LEN_NIJ - 1);
    localparam dcnt_t  TOTAL_C  = dcnt_t'(LEN_NIJ * LEN_KIJ);

    seq_state_t  state_q, state_d;
    kij_t        kij_q, kij_d, kij_inc_s;
    t_cnt_t      t_q, t_d;
    logic        cen0_q, cen0_d;
    xaddr_t      a0_q, a0_d, ld_addr_s;
    logic [2:0]  ctl_p0_q, ctl_p0_d, ctl_p1_q, ctl_p1_d, ctl_p2_q, ctl_p2_d;
    logic        l0_wr_q, l0_wr_d, l0_rd_q, l0_rd_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        start_acc_s;
    logic        ofifo_rd_s, cen_pmem_s, wen_pmem_s;
    paddr_t      a_pmem_s;
    dcnt_t       drain_cnt_s;
    logic [INST_W-1:0] inst_s;

    assign ld_addr_s = W_BASE + xaddr_t'(kij_q) * xaddr_t'(COL) + xaddr_t'(t_q);
    assign kij_inc_s = kij_q + kij_t'(1'b1);

    // Next-state logic and xmem read issue for the current state.
    always_comb begin
        state_d     = state_q;
        kij_d       = kij_q;
        t_d         = t_q;
        cen0_d      = 1'b1;
        a0_d        = '0;
        ctl_p0_d    = CTL_NONE;
        start_acc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    kij_d       = '0;
                    t_d         = '0;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (l0_ready) begin
                    cen0_d   = 1'b0;
                    a0_d     = ld_addr_s;
                    ctl_p0_d = CTL_LOAD;
                    if (t_q == COL_LAST) begin
                        t_d     = '0;
                        state_d = S_EXEC;
                    end else begin
                        t_d = t_q + t_cnt_t'(1'b1);
                    end
                end else begin
                    t_d = t_q;
                end
            end
            S_EXEC: begin
                if (l0_ready) begin
                    cen0_d   = 1'b0;
                    a0_d     = xaddr_t'(t_q);
                    ctl_p0_d = CTL_EXEC;
                    if (t_q == NIJ_LAST) begin
                        t_d     = '0;
                        state_d = S_FLUSH;
                    end else begin
                        t_d = t_q + t_cnt_t'(1'b1);
                    end
                end else begin
                    t_d = t_q;
                end
            end
            S_FLUSH: begin
                ctl_p0_d = CTL_FLUSH;
                state_d  = S_NEXT;
            end
            S_NEXT: begin
                kij_d = kij_inc_s;
                if (int'(kij_inc_s) < LEN_KIJ) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT_DRAIN;
                end
            end
            S_WAIT_DRAIN: begin
                if (drain_cnt_s == TOTAL_C) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // L0 strobes and the two-stage control delay behind the read fields.
    always_comb begin
        l0_wr_d  = ~cen0_q;
        l0_rd_d  = l0_wr_q;
        ctl_p1_d = ctl_p0_q;
        ctl_p2_d = ctl_p1_q;
    end

    // Sequencer and instruction pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kij_q    <= '0;
            t_q      <= '0;
            cen0_q   <= 1'b1;
            a0_q     <= '0;
            ctl_p0_q <= CTL_NONE;
            ctl_p1_q <= CTL_NONE;
            ctl_p2_q <= CTL_NONE;
            l0_wr_q  <= 1'b0;
            l0_rd_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kij_q    <= kij_d;
            t_q      <= t_d;
            cen0_q   <= cen0_d;
            a0_q     <= a0_d;
            ctl_p0_q <= ctl_p0_d;
            ctl_p1_q <= ctl_p1_d;
            ctl_p2_q <= ctl_p2_d;
            l0_wr_q  <= l0_wr_d;
            l0_rd_q  <= l0_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    psum_drain_ctrl #(
        .TOTAL (LEN_NIJ * LEN_KIJ)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .clr         (start_acc_s),
        .en          (busy_q),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd_s),
        .cen_pmem    (cen_pmem_s),
        .wen_pmem    (wen_pmem_s),
        .a_pmem      (a_pmem_s),
        .drain_cnt   (drain_cnt_s)
    );

    // Assemble the instruction word; unused fields stay at their fixed values.
    always_comb begin
        inst_s                             = '0;
        inst_s[B_ACC]                      = 1'b0;
        inst_s[B_CEN1]                     = 1'b1;
        inst_s[B_WEN0]                     = 1'b1;
        inst_s[B_CEN0]                     = cen0_q;
        inst_s[B_A0_MSB:B_A0_LSB]          = a0_q;
        inst_s[B_L0_WR]                    = l0_wr_q;
        inst_s[B_L0_RD]                    = l0_rd_q;
        inst_s[B_MODE:B_LOAD]              = ctl_p2_q;
        inst_s[B_OFIFO_RD]                 = ofifo_rd_s;
        inst_s[B_CEN_PMEM]                 = cen_pmem_s;
        inst_s[B_WEN_PMEM]                 = wen_pmem_s;
        inst_s[B_A_PMEM_MSB:B_A_PMEM_LSB]  = a_pmem_s;
    end

    assign inst = inst_s;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Scoreboard bench for conv_inst_sequencer with two kernel positions per pass.
module tb_conv_inst_sequencer;

    localparam int COL   = 8;
    localparam int NIJ   = 1024;
    localparam int KIJ   = 2;
    localparam int TOTAL = NIJ * KIJ;
    // CEN_pmem(48), WEN_pmem(47), CEN1(32), CEN0(20), WEN0(19) set; rest 0.
    localparam logic [49:0] IDLE_INST = 50'h1_8001_0018_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        l0_ready = 1'b1;
    logic        ofifo_valid = 1'b0;
    logic [49:0] inst;
    logic        busy;
    logic        done;

    conv_inst_sequencer #(
        .COL     (COL),
        .LEN_NIJ (NIJ),
        .LEN_KIJ (KIJ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .l0_ready    (l0_ready),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        bit          is_exec;
        bit          last;
    } rd_t;

    rd_t        rdq[$];
    logic [4:0] exp_low [int];
    int         ld_cyc[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         active = 1'b0;
    bit         was_active;
    int         wr_model = 0;
    int         n_done = 0;
    int         last_exec_addr = -1;
    logic       prev_ready = 1'b0;
    logic [4:0] el;
    bit         exp_rd;
    rd_t        r;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic add_exp(input int k, input logic [4:0] v);
        if (!exp_low.exists(k)) exp_low[k] = 5'd0;
        exp_low[k] = exp_low[k] | v;
    endtask

    task automatic push_pass();
        rd_t e;
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < COL; i++) begin
                e.addr = 11'(32'h400 + k * COL + i); e.is_exec = 1'b0; e.last = 1'b0;
                rdq.push_back(e);
            end
            for (int i = 0; i < NIJ; i++) begin
                e.addr = 11'(i); e.is_exec = 1'b1; e.last = (i == NIJ - 1);
                rdq.push_back(e);
            end
        end
    endtask

    // Monitor: compare every cycle against the scoreboard, sampled on negedge.
    always @(negedge clk) begin
        cyc++;
        el = 5'd0;
        if (exp_low.exists(cyc)) begin
            el = exp_low[cyc];
            exp_low.delete(cyc);
        end
        check_eq("low_fields", {59'd0, inst[4:0]}, {59'd0, el});
        check_eq("fixed_fields", {inst[49], inst[32], inst[31:21], inst[19], inst[6], inst[5]},
                 {1'b0, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0});
        if (!prev_ready) check_eq("stall_cen0", inst[20], 1'b1);
        if (inst[20] == 1'b0) begin
            check_eq("read_expected", rdq.size() > 0, 1'b1);
            if (rdq.size() > 0) begin
                r = rdq.pop_front();
                check_eq("a0", inst[18:8], r.addr);
                add_exp(cyc + 1, 5'b01000);
                add_exp(cyc + 2, r.is_exec ? 5'b10010 : 5'b10001);
                if (r.last) add_exp(cyc + 3, 5'b00111);
                if (r.is_exec) last_exec_addr = int'(r.addr);
                else ld_cyc.push_back(cyc);
            end
        end
        exp_rd = ofifo_valid && active && (wr_model < TOTAL);
        check_eq("ofifo_rd", inst[7], exp_rd);
        if (exp_rd) begin
            check_eq("pmem_wr", {inst[48], inst[47], inst[46:33]}, {2'b00, 14'(wr_model)});
            wr_model++;
        end else begin
            check_eq("pmem_idle", {inst[48], inst[47], inst[46:33]}, {2'b11, 14'd0});
        end
        was_active = active;
        if (active && done) begin
            n_done++;
            check_eq("busy_at_done", busy, 1'b0);
            check_eq("done_wr_count", wr_model, TOTAL);
            check_eq("done_reads_left", rdq.size(), 0);
            active = 1'b0;
        end else begin
            check_eq("busy", busy, active);
            check_eq("done_idle", done, 1'b0);
        end
        if (reset) begin
            rdq.delete();
            exp_low.delete();
            active   = 1'b0;
            wr_model = 0;
        end else if (start && !was_active) begin
            push_pass();
            active   = 1'b1;
            wr_model = 0;
        end
        prev_ready = l0_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready always, 1 alternating. vmode: 1 valid always, 3 one-of-three.
    task automatic run_pass(input int rmode, input int vmode, input bit poke, input int budget,
                            input string tag);
        int base = n_done;
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n_done == base && k < budget) begin
            l0_ready    = (rmode == 1) ? k[0] : 1'b1;
            ofifo_valid = (vmode == 3) ? (k % 3 == 0) : 1'b1;
            start       = poke && (k == 300);
            tick();
            k++;
        end
        start = 1'b0;
        l0_ready = 1'b1;
        repeat (4) begin
            ofifo_valid = 1'b1;
            tick();
        end
        ofifo_valid = 1'b0;
        check_eq({tag, "_done_once"}, n_done - base, 1);
    endtask

    initial begin
        int k;
        int base;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_inst", inst, IDLE_INST);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        tick();

        // Test 1: no drain; all reads issue, busy holds in WAIT_DRAIN.
        base = n_done;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (rdq.size() > 0 && k < 5000) begin tick(); k++; end
        check_eq("t1_reads_issued", rdq.size(), 0);
        repeat (20) tick();
        @(negedge clk);
        check_eq("t1_wait_drain_busy", busy, 1'b1);
        check_eq("t1_no_done", n_done - base, 0);
        tick();
        k = 0;
        ofifo_valid = 1'b1;
        while (n_done == base && k < 5000) begin tick(); k++; end
        ofifo_valid = 1'b0;
        check_eq("t1_done_once", n_done - base, 1);
        tick();

        // Test 2: l0_ready alternating.
        ld_cyc.delete();
        run_pass(1, 1, 1'b0, 10000, "t2");
        check_eq("t2_load_reads", ld_cyc.size(), 2 * COL);
        if (ld_cyc.size() >= COL) check_eq("t2_load_span", ld_cyc[COL-1] - ld_cyc[0], 2 * (COL - 1));

        // Test 3 + 5a: continuous drain, stray start during EXEC.
        run_pass(0, 1, 1'b1, 6000, "t3");

        // Test 4: reset mid-EXEC, then restart.
        last_exec_addr = -1;
        ofifo_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (last_exec_addr != 500 && k < 3000) begin tick(); k++; end
        check_eq("t4_reach_t500", last_exec_addr, 500);
        reset = 1'b1; tick(); reset = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_idle_inst", inst, IDLE_INST);
        check_eq("t4_idle_busy", busy, 1'b0);
        tick();
        run_pass(0, 1, 1'b0, 6000, "t4_restart");

        // Test 5b: start and reset together keeps the block idle.
        start = 1'b1; reset = 1'b1; tick(); start = 1'b0; reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_inst", inst, IDLE_INST);
        tick();

        // Test 6: ofifo_valid one cycle in three.
        run_pass(0, 3, 1'b0, 10000, "t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
